// File: rtl/mem_port_arbiter_if.sv
// Shared RAM port bundle: CPU and debug requesters, RAM macro side, status.
// The arbiter takes the slave view; the requesters/RAM side take master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              cpu_hold;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic              dbg_lock;
  logic              locked;

  logic [DATA_W-1:0] rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [CNT_W-1:0]  cpu_cnt;
  logic [CNT_W-1:0]  dbg_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_hold,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid,
    input  dbg_lock,
    output locked, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output cpu_cnt, dbg_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_hold,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid,
    output dbg_lock,
    input  locked, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  cpu_cnt, dbg_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port RAM arbiter: round-robin CPU/debug access with a debug lock
// that freezes the CPU out while a program image is loaded.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              last_q;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              cpu_rv_q;
  logic              dbg_rv_q;
  logic [CNT_W-1:0]  cpu_cnt_q;
  logic [CNT_W-1:0]  dbg_cnt_q;
  logic              we_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // last_q: 1 = debug was granted most recently
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      last_q    <= 1'b1;
      cpu_rv_q  <= 1'b0;
      dbg_rv_q  <= 1'b0;
      cpu_cnt_q <= '0;
      dbg_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cpu_rv_q <= cpu_gnt & ~bus.cpu_we;
      dbg_rv_q <= dbg_gnt & ~bus.dbg_we;
      if (state_q == ARB && (cpu_gnt | dbg_gnt))
        last_q <= dbg_gnt;
      if (cpu_gnt)
        cpu_cnt_q <= cpu_cnt_q + 1'b1;
      if (dbg_gnt)
        dbg_cnt_q <= dbg_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    unique case (state_q)
      ARB: begin
        state_d = bus.dbg_lock ? LOCKED : ARB;
        if (bus.cpu_req && bus.dbg_req) begin
          cpu_gnt = last_q;
          dbg_gnt = ~last_q;
        end else begin
          cpu_gnt = bus.cpu_req;
          dbg_gnt = bus.dbg_req;
        end
      end
      LOCKED: begin
        state_d = bus.dbg_lock ? LOCKED : ARB;
        dbg_gnt = bus.dbg_req;
      end
      default: state_d = ARB;
    endcase
    if (reset) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  always_comb begin
    we_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    unique case (1'b1)
      cpu_gnt: begin
        we_mux    = bus.cpu_we;
        addr_mux  = bus.cpu_addr;
        wdata_mux = bus.cpu_wdata;
      end
      dbg_gnt: begin
        we_mux    = bus.dbg_we;
        addr_mux  = bus.dbg_addr;
        wdata_mux = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_hold   = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.dbg_rvalid = dbg_rv_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.rdata      = bus.ram_rdata;
  assign bus.ram_en     = cpu_gnt | dbg_gnt;
  assign bus.ram_we     = we_mux;
  assign bus.ram_addr   = addr_mux;
  assign bus.ram_wdata  = wdata_mux;
  assign bus.cpu_cnt    = cpu_cnt_q;
  assign bus.dbg_cnt    = dbg_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM behind it.
// Inputs change 1ns after posedge; outputs are checked away from the edge.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hA5;
    bus.ram_rdata = '0;
    bus.dbg_lock  = 1'b0;
    reset = 1'b1;
    idle();
    tick();

    // requests are ignored while reset is held
    bus.cpu_req = 1'b1;
    #1;
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
    chk("rst_ram_en", 32'(bus.ram_en), 0);
    tick();
    chk("rst_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("rst_cpu_cnt", 32'(bus.cpu_cnt), 0);
    chk("rst_dbg_cnt", 32'(bus.dbg_cnt), 0);
    chk("rst_locked", 32'(bus.locked), 0);

    // single CPU read
    reset = 1'b0;
    bus.cpu_addr = 8'h10;
    #1;
    chk("rd_cpu_gnt", 32'(bus.cpu_gnt), 1);
    chk("rd_ram_en", 32'(bus.ram_en), 1);
    chk("rd_ram_addr", 32'(bus.ram_addr), 32'h10);
    tick();
    idle();
    chk("rd_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("rd_rdata", 32'(bus.rdata), 32'hA5);
    chk("rd_cpu_cnt", 32'(bus.cpu_cnt), 1);
    tick();
    chk("rd_rvalid_1cyc", 32'(bus.cpu_rvalid), 0);

    // contention from reset: CPU, DBG, CPU, DBG
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 8'h01;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_cpu_gnt", 32'(bus.cpu_gnt), (i % 2 == 0) ? 1 : 0);
      chk("rr_dbg_gnt", 32'(bus.dbg_gnt), (i % 2 == 1) ? 1 : 0);
      chk("rr_hold", 32'(bus.cpu_hold), (i % 2 == 1) ? 1 : 0);
      tick();
    end
    idle();
    chk("rr_cpu_cnt", 32'(bus.cpu_cnt), 2);
    chk("rr_dbg_cnt", 32'(bus.dbg_cnt), 2);

    // debug lock with image write while CPU waits
    bus.dbg_lock = 1'b1;
    tick();
    chk("lk_locked", 32'(bus.locked), 1);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 8'h10;
    for (int i = 0; i < 5; i++) begin
      bus.dbg_req   = (i < 4);
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 8'(i);
      bus.dbg_wdata = 8'h3C;
      #1;
      chk("lk_cpu_gnt", 32'(bus.cpu_gnt), 0);
      chk("lk_hold", 32'(bus.cpu_hold), 1);
      chk("lk_dbg_gnt", 32'(bus.dbg_gnt), (i < 4) ? 1 : 0);
      tick();
    end
    bus.dbg_req  = 1'b0;
    bus.dbg_we   = 1'b0;
    bus.dbg_lock = 1'b0;
    #1;
    chk("lk_drop_gnt", 32'(bus.cpu_gnt), 0);
    tick();
    chk("lk_unlocked", 32'(bus.locked), 0);
    #1;
    chk("lk_after_gnt", 32'(bus.cpu_gnt), 1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) chk("lk_mem", 32'(mem[i]), 32'h3C);

    // read granted in the same cycle the lock rises
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 8'h10;
    bus.dbg_lock = 1'b1;
    #1;
    chk("lr_cpu_gnt", 32'(bus.cpu_gnt), 1);
    chk("lr_locked0", 32'(bus.locked), 0);
    tick();
    bus.cpu_req = 1'b0;
    chk("lr_locked1", 32'(bus.locked), 1);
    chk("lr_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("lr_rdata", 32'(bus.rdata), 32'hA5);
    bus.dbg_lock = 1'b0;
    tick();
    chk("lr_unlocked", 32'(bus.locked), 0);

    // debug counter wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 127) chk("wr_cnt_128", 32'(bus.dbg_cnt), 128);
      if (i == 254) chk("wr_cnt_ff", 32'(bus.dbg_cnt), 32'hFF);
    end
    chk("wr_cnt_wrap", 32'(bus.dbg_cnt), 0);
    chk("wr_cpu_cnt", 32'(bus.cpu_cnt), 0);

    // reset right after a debug read grant drops the rvalid
    bus.dbg_addr = 8'h10;
    #1;
    chk("rr2_dbg_gnt", 32'(bus.dbg_gnt), 1);
    tick();
    idle();
    reset = 1'b1;
    #1;
    chk("rr2_no_gnt", 32'(bus.ram_en), 0);
    tick();
    chk("rr2_rvalid", 32'(bus.dbg_rvalid), 0);
    chk("rr2_dbg_cnt", 32'(bus.dbg_cnt), 0);
    chk("rr2_cpu_cnt", 32'(bus.cpu_cnt), 0);
    chk("rr2_locked", 32'(bus.locked), 0);
    reset = 1'b0;
    tick();
    chk("rr2_rvalid_post", 32'(bus.dbg_rvalid), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
